// File: rtl/matrix_relu_maxpool.sv
// ReLU fused with non-overlapping POOL x POOL max pooling over the convolution result
// held in shared single-port RAM. The header (wA, hA, wF, hF) is read first, then every
// pooling window is read in row-major order, reduced with a signed max seeded at zero
// (which is what gives the ReLU), and the pooled word is written right after the
// convolution result. One memory request is in flight at a time, and there is always at
// least one idle cycle between requests.
module matrix_relu_maxpool #(
    parameter int POOL = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        mem_opdone,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic [31:0] addr_o,
    output logic [1:0]  mem_operation,
    output logic        done
);

    typedef enum logic [3:0] {
        IDLE,
        START,
        FETCH_PARAMS,
        CHECK,
        LOOP_OY,
        LOOP_OX,
        LOAD_ELEM,
        COMPARE,
        WRITE_RESULT,
        FSM_DONE
    } state_t;

    localparam logic [31:0] POOL_W    = 32'(POOL);
    localparam logic [31:0] POOL_LAST = 32'(POOL - 1);
    localparam logic [1:0]  OP_NONE   = 2'b00;
    localparam logic [1:0]  OP_READ   = 2'b01;
    localparam logic [1:0]  OP_WRITE  = 2'b11;

    state_t      state;
    state_t      next_state;

    logic [31:0] wa;
    logic [31:0] ha;
    logic [31:0] wf;
    logic [31:0] hf;
    logic [1:0]  param_idx;
    logic        param_gap;
    logic [31:0] oy;
    logic [31:0] ox;
    logic [31:0] ky;
    logic [31:0] kx;
    logic [31:0] acc;
    logic [31:0] rd_data;
    logic        done_q;

    logic [31:0] rw;
    logic [31:0] rh;
    logic [31:0] res_base;
    logic [31:0] pool_base;
    logic [31:0] pw;
    logic [31:0] ph;
    logic [31:0] elem_addr;
    logic [31:0] out_addr;
    logic        params_bad;
    logic        window_last;

    // Geometry derived from the latched header; everything wraps modulo 2^32.
    assign rw          = wa - wf + 32'd1;
    assign rh          = ha - hf + 32'd1;
    assign res_base    = 32'd4 + 32'd2 * ha * wa + hf * wf;
    assign pool_base   = res_base + rh * rw;
    assign pw          = rw / POOL_W;
    assign ph          = rh / POOL_W;
    assign elem_addr   = res_base + (oy * POOL_W + ky) * rw + (ox * POOL_W + kx);
    assign out_addr    = pool_base + oy * pw + ox;
    assign params_bad  = (wf > wa) || (hf > ha) || (wf == 32'd0) || (hf == 32'd0) ||
                         (pw == 32'd0) || (ph == 32'd0);
    assign window_last = (kx == POOL_LAST) && (ky == POOL_LAST);

    // State register; reset aborts whatever request is outstanding.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; memory states only advance on the cycle the request completes.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:         if (enable) next_state = START;
            START:        next_state = FETCH_PARAMS;
            FETCH_PARAMS: if (!param_gap && mem_opdone && param_idx == 2'd3) next_state = CHECK;
            CHECK:        next_state = params_bad ? FSM_DONE : LOOP_OY;
            LOOP_OY:      next_state = (oy < ph) ? LOOP_OX : FSM_DONE;
            LOOP_OX:      next_state = (ox < pw) ? LOAD_ELEM : LOOP_OY;
            LOAD_ELEM:    if (mem_opdone) next_state = COMPARE;
            COMPARE:      next_state = window_last ? WRITE_RESULT : LOAD_ELEM;
            WRITE_RESULT: if (mem_opdone) next_state = LOOP_OX;
            FSM_DONE:     if (!enable) next_state = IDLE;
            default:      next_state = IDLE;
        endcase
    end

    // Memory request outputs; the bus is quiet (all zero) whenever no request is pending.
    always_comb begin
        mem_operation = OP_NONE;
        addr_o        = 32'd0;
        data_o        = 32'd0;
        case (state)
            FETCH_PARAMS: begin
                if (!param_gap) begin
                    mem_operation = OP_READ;
                    addr_o        = {30'd0, param_idx};
                end
            end
            LOAD_ELEM: begin
                mem_operation = OP_READ;
                addr_o        = elem_addr;
            end
            WRITE_RESULT: begin
                mem_operation = OP_WRITE;
                addr_o        = out_addr;
                data_o        = acc;
            end
            default: begin
                mem_operation = OP_NONE;
            end
        endcase
    end

    assign done = done_q;

    // done rises together with FSM_DONE and stays up through IDLE until the next START.
    always_ff @(posedge clk) begin
        if (reset) begin
            done_q <= 1'b0;
        end else if (next_state == START) begin
            done_q <= 1'b0;
        end else if (next_state == FSM_DONE) begin
            done_q <= 1'b1;
        end
    end

    // Datapath: header latches, window/output counters and the running signed maximum.
    always_ff @(posedge clk) begin
        if (reset) begin
            wa        <= 32'd0;
            ha        <= 32'd0;
            wf        <= 32'd0;
            hf        <= 32'd0;
            param_idx <= 2'd0;
            param_gap <= 1'b0;
            oy        <= 32'd0;
            ox        <= 32'd0;
            ky        <= 32'd0;
            kx        <= 32'd0;
            acc       <= 32'd0;
            rd_data   <= 32'd0;
        end else begin
            case (state)
                START: begin
                    wa        <= 32'd0;
                    ha        <= 32'd0;
                    wf        <= 32'd0;
                    hf        <= 32'd0;
                    param_idx <= 2'd0;
                    param_gap <= 1'b0;
                    oy        <= 32'd0;
                    ox        <= 32'd0;
                    ky        <= 32'd0;
                    kx        <= 32'd0;
                    acc       <= 32'd0;
                    rd_data   <= 32'd0;
                end
                FETCH_PARAMS: begin
                    if (param_gap) begin
                        param_gap <= 1'b0;
                    end else if (mem_opdone) begin
                        case (param_idx)
                            2'd0:    wa <= data_i;
                            2'd1:    ha <= data_i;
                            2'd2:    wf <= data_i;
                            default: hf <= data_i;
                        endcase
                        param_idx <= param_idx + 2'd1;
                        param_gap <= 1'b1;
                    end
                end
                CHECK: begin
                    oy <= 32'd0;
                end
                LOOP_OY: begin
                    if (oy < ph) begin
                        ox <= 32'd0;
                    end
                end
                LOOP_OX: begin
                    if (ox < pw) begin
                        ky  <= 32'd0;
                        kx  <= 32'd0;
                        acc <= 32'd0;
                    end else begin
                        oy <= oy + 32'd1;
                    end
                end
                LOAD_ELEM: begin
                    if (mem_opdone) begin
                        rd_data <= data_i;
                    end
                end
                COMPARE: begin
                    if ($signed(rd_data) > $signed(acc)) begin
                        acc <= rd_data;
                    end
                    if (kx == POOL_LAST) begin
                        kx <= 32'd0;
                        if (ky != POOL_LAST) begin
                            ky <= ky + 32'd1;
                        end
                    end else begin
                        kx <= kx + 32'd1;
                    end
                end
                WRITE_RESULT: begin
                    if (mem_opdone) begin
                        ox <= ox + 32'd1;
                    end
                end
                default: begin
                    param_gap <= param_gap;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_matrix_relu_maxpool.sv
// Bench for matrix_relu_maxpool: a RAM model answers requests after random delays and logs
// every read and write; a loop-based reference computes the expected read order and the
// pooled writes straight from the header arithmetic.
module tb_matrix_relu_maxpool;

    localparam int POOL = 2;

    logic        clk;
    logic        reset;
    logic        enable;
    logic        mem_opdone;
    logic [31:0] data_i;
    logic [31:0] data_o;
    logic [31:0] addr_o;
    logic [1:0]  mem_operation;
    logic        done;

    int n_checks = 0;
    int n_fails  = 0;

    logic [31:0] mem [0:1023];
    int unsigned max_delay = 0;

    logic [31:0] rd_log[$];
    logic [31:0] wr_addr_log[$];
    logic [31:0] wr_data_log[$];
    logic [31:0] exp_rd[$];
    logic [31:0] exp_wa[$];
    logic [31:0] exp_wd[$];

    matrix_relu_maxpool #(.POOL(POOL)) dut (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .mem_opdone    (mem_opdone),
        .data_i        (data_i),
        .data_o        (data_o),
        .addr_o        (addr_o),
        .mem_operation (mem_operation),
        .done          (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_fails++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    // RAM model: answers after a random delay, checks the request is held and that an idle cycle follows.
    initial begin
        logic        busy;
        int unsigned wait_cnt;
        logic [1:0]  h_op;
        logic [31:0] h_addr;
        logic [31:0] h_data;
        busy       = 1'b0;
        wait_cnt   = 0;
        h_op       = 2'b00;
        h_addr     = 32'd0;
        h_data     = 32'd0;
        mem_opdone = 1'b0;
        data_i     = 32'd0;
        forever begin
            @(negedge clk);
            if (reset) begin
                mem_opdone = 1'b0;
                busy       = 1'b0;
            end else if (mem_opdone) begin
                mem_opdone = 1'b0;
                busy       = 1'b0;
                checkOutput("idle_after_opdone", {30'd0, mem_operation}, 32'd0);
            end else if (mem_operation != 2'b00) begin
                if (!busy) begin
                    busy     = 1'b1;
                    h_op     = mem_operation;
                    h_addr   = addr_o;
                    h_data   = data_o;
                    wait_cnt = $urandom_range(max_delay, 0);
                end else begin
                    checkOutput("hold_op", {30'd0, mem_operation}, {30'd0, h_op});
                    checkOutput("hold_addr", addr_o, h_addr);
                    if (h_op == 2'b11) checkOutput("hold_data", data_o, h_data);
                end
                if (wait_cnt == 0) begin
                    if (mem_operation == 2'b11) begin
                        mem[addr_o[9:0]] = data_o;
                        wr_addr_log.push_back(addr_o);
                        wr_data_log.push_back(data_o);
                    end else begin
                        data_i = mem[addr_o[9:0]];
                        rd_log.push_back(addr_o);
                    end
                    mem_opdone = 1'b1;
                end else begin
                    wait_cnt--;
                end
            end
        end
    end

    task automatic loadHeader(input logic [31:0] wa, input logic [31:0] ha,
                              input logic [31:0] wf, input logic [31:0] hf);
        mem[0] = wa;
        mem[1] = ha;
        mem[2] = wf;
        mem[3] = hf;
    endtask

    // Reference: plain loops over output positions and window elements.
    task automatic buildModel();
        logic [31:0] wa, ha, wf, hf, rw, rh, rb, pb, pw, ph, a;
        int best;
        wa = mem[0]; ha = mem[1]; wf = mem[2]; hf = mem[3];
        rw = wa - wf + 32'd1;
        rh = ha - hf + 32'd1;
        rb = 32'd4 + 32'd2 * ha * wa + hf * wf;
        pb = rb + rh * rw;
        pw = rw / 32'(POOL);
        ph = rh / 32'(POOL);
        exp_rd.delete();
        exp_wa.delete();
        exp_wd.delete();
        for (int i = 0; i < 4; i++) exp_rd.push_back(32'(i));
        if (wf > wa || hf > ha || wf == 0 || hf == 0 || pw == 0 || ph == 0) return;
        for (int oy = 0; oy < int'(ph); oy++) begin
            for (int ox = 0; ox < int'(pw); ox++) begin
                best = 0;
                for (int ky = 0; ky < POOL; ky++) begin
                    for (int kx = 0; kx < POOL; kx++) begin
                        a = rb + 32'(oy * POOL + ky) * rw + 32'(ox * POOL + kx);
                        exp_rd.push_back(a);
                        if ($signed(mem[a[9:0]]) > best) best = $signed(mem[a[9:0]]);
                    end
                end
                exp_wa.push_back(pb + 32'(oy) * pw + 32'(ox));
                exp_wd.push_back(32'(best));
            end
        end
    endtask

    // One full run: enable, wait for done (bounded), then compare the logged traffic to the model.
    task automatic applyStimulus(input int tid);
        bit seen;
        int n;
        rd_log.delete();
        wr_addr_log.delete();
        wr_data_log.delete();
        buildModel();
        enable = 1'b1;
        @(negedge clk);
        checkOutput($sformatf("t%0d_done_low_at_start", tid), {31'd0, done}, 32'd0);
        seen = 1'b0;
        for (int c = 0; c < 20000 && !seen; c++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        checkOutput($sformatf("t%0d_done_reached", tid), {31'd0, seen}, 32'd1);
        checkOutput($sformatf("t%0d_op_none_at_done", tid), {30'd0, mem_operation}, 32'd0);
        enable = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput($sformatf("t%0d_done_held_idle", tid), {31'd0, done}, 32'd1);
        checkOutput($sformatf("t%0d_num_reads", tid), rd_log.size(), exp_rd.size());
        n = (rd_log.size() < exp_rd.size()) ? rd_log.size() : exp_rd.size();
        for (int i = 0; i < n; i++)
            checkOutput($sformatf("t%0d_rd%0d_addr", tid, i), rd_log[i], exp_rd[i]);
        checkOutput($sformatf("t%0d_num_writes", tid), wr_addr_log.size(), exp_wa.size());
        n = (wr_addr_log.size() < exp_wa.size()) ? wr_addr_log.size() : exp_wa.size();
        for (int i = 0; i < n; i++) begin
            checkOutput($sformatf("t%0d_wr%0d_addr", tid, i), wr_addr_log[i], exp_wa[i]);
            checkOutput($sformatf("t%0d_wr%0d_data", tid, i), wr_data_log[i], exp_wd[i]);
        end
    endtask

    task automatic fillCounting();
        loadHeader(5, 5, 2, 2);
        for (int i = 0; i < 16; i++) mem[58 + i] = 32'(i + 1);
    endtask

    initial begin
        logic [31:0] t1_addr [4];
        logic [31:0] t1_data [4];
        logic [31:0] v;
        bit          seen;
        t1_addr = '{32'd74, 32'd75, 32'd76, 32'd77};
        t1_data = '{32'd6, 32'd8, 32'd14, 32'd16};
        for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
        reset  = 1'b1;
        enable = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_op", {30'd0, mem_operation}, 32'd0);
        checkOutput("reset_addr", addr_o, 32'd0);
        checkOutput("reset_data", data_o, 32'd0);
        checkOutput("reset_done", {31'd0, done}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        $display("[TB] test 1: counting result matrix");
        fillCounting();
        applyStimulus(1);
        checkOutput("t1_fixed_count", wr_addr_log.size(), 32'd4);
        if (wr_addr_log.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                checkOutput($sformatf("t1_fixed_addr%0d", i), wr_addr_log[i], t1_addr[i]);
                checkOutput($sformatf("t1_fixed_data%0d", i), wr_data_log[i], t1_data[i]);
            end
        end

        $display("[TB] test 2: all-negative windows");
        for (int i = 0; i < 16; i++) mem[58 + i] = 32'hFFFF_FFFD;
        applyStimulus(2);
        for (int i = 0; i < 4; i++)
            checkOutput($sformatf("t2_mem%0d_relu", i), mem[74 + i], 32'd0);

        $display("[TB] test 3: odd result size, trailing row/col dropped");
        loadHeader(5, 5, 1, 1);
        for (int i = 0; i < 25; i++) mem[55 + i] = $urandom;
        applyStimulus(3);

        $display("[TB] test 4: filter larger than input");
        loadHeader(2, 2, 3, 3);
        applyStimulus(4);

        $display("[TB] test 5: random headers, data and delays");
        max_delay = 5;
        for (int it = 0; it < 6; it++) begin
            loadHeader($urandom_range(7, 2), $urandom_range(7, 2), $urandom_range(3, 1), $urandom_range(3, 1));
            for (int i = 4; i < 200; i++) begin
                case ($urandom_range(4, 0))
                    0:       v = 32'h8000_0000;
                    1:       v = 32'd0;
                    2:       v = 32'h7FFF_FFFF;
                    3:       v = 32'(-int'($urandom_range(1000, 1)));
                    default: v = $urandom;
                endcase
                mem[i] = v;
            end
            applyStimulus(5);
        end

        $display("[TB] test 6: reset during write, then rerun");
        max_delay = 2;
        fillCounting();
        for (int i = 74; i < 78; i++) mem[i] = 32'd0;
        enable = 1'b1;
        seen   = 1'b0;
        for (int c = 0; c < 2000 && !seen; c++) begin
            @(negedge clk);
            if (mem_operation == 2'b11) seen = 1'b1;
        end
        checkOutput("t6_write_seen", {31'd0, seen}, 32'd1);
        reset  = 1'b1;
        enable = 1'b0;
        @(negedge clk);
        checkOutput("t6_op_after_reset", {30'd0, mem_operation}, 32'd0);
        checkOutput("t6_done_after_reset", {31'd0, done}, 32'd0);
        checkOutput("t6_addr_after_reset", addr_o, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("t6_idle_op", {30'd0, mem_operation}, 32'd0);
        max_delay = 5;
        applyStimulus(6);
        for (int i = 0; i < 4; i++)
            checkOutput($sformatf("t6_mem%0d", i), mem[74 + i], t1_data[i]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
